// File: rtl/stage_fetch_multi.sv
// Decoupled multi-slot fetch stage: one aligned bundle request in flight to the icache,
// predecode of the latched bundle, predictor query and truncated push into the instruction buffer.
module stage_fetch_multi #(
   parameter int          FETCH_WIDTH = 4,
   parameter int          IB_CNT_W    = 4,
   parameter logic [31:0] RESET_PC    = 32'h0,
   parameter bit          JALR_STALL  = 1'b1
) (
   input  logic                        clock,
   input  logic                        reset_n,
   output logic                        ic_req_valid,
   input  logic                        ic_req_ready,
   output logic [31:0]                 ic_req_addr,
   input  logic                        ic_resp_valid,
   input  logic [32*FETCH_WIDTH-1:0]   ic_resp_data,
   output logic                        bp_req_valid,
   output logic [31:0]                 bp_req_pc,
   input  logic                        bp_resp_taken,
   input  logic [31:0]                 bp_resp_target,
   input  logic                        redirect_valid,
   input  logic [31:0]                 redirect_pc,
   input  logic [IB_CNT_W-1:0]         ib_free_slots,
   output logic [FETCH_WIDTH-1:0]      fetch_valid,
   output logic [32*FETCH_WIDTH-1:0]   fetch_pc,
   output logic [32*FETCH_WIDTH-1:0]   fetch_inst,
   output logic [FETCH_WIDTH-1:0]      fetch_is_branch,
   output logic                        fetch_pred_taken,
   output logic [31:0]                 fetch_pred_target,
   output logic [1:0]                  dbg_state
);

   localparam int BB     = FETCH_WIDTH * 4;
   localparam int OFF_W  = $clog2(BB);
   localparam int SLOT_W = $clog2(FETCH_WIDTH);

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_BLOCK} state_t;

   // Handshakes: a request or response transfers on the rising edge where valid and ready
   // (resp: valid while in WAIT) are both high; valid never depends on the same-cycle ready.
   state_t                     state, state_n;
   logic [31:0]                pc, pc_n;
   logic                       kill, kill_n;
   logic [31:0]                base;
   logic [SLOT_W-1:0]          start;
   logic [32*FETCH_WIDTH-1:0]  bundle;
   logic                       capture, latch;

   logic                       in_hold, cf_found, is_br, is_jal, is_jalr, truncate;
   logic [SLOT_W-1:0]          cf_slot;
   logic [31:0]                cf_word, slot_pc, jimm, seq_pc, next_pc;
   logic [FETCH_WIDTH-1:0]     mask;
   logic [SLOT_W:0]            count;
   logic                       room, push, block_next;
   logic                       unused_bits;

   assign in_hold = (state == S_HOLD);

   always_comb begin
      cf_found = 1'b0;
      cf_slot  = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         logic [6:0] opc;
         opc = bundle[32*i +: 7];
         if (!cf_found && i >= int'(start) &&
             (opc == OP_BRANCH || opc == OP_JAL || opc == OP_JALR)) begin
            cf_found = 1'b1;
            cf_slot  = SLOT_W'(i);
         end
      end
   end

   assign cf_word  = bundle[32*cf_slot +: 32];
   assign is_br    = cf_found && (cf_word[6:0] == OP_BRANCH);
   assign is_jal   = cf_found && (cf_word[6:0] == OP_JAL);
   assign is_jalr  = cf_found && (cf_word[6:0] == OP_JALR);
   assign slot_pc  = base + (32'(cf_slot) << 2);
   assign jimm     = {{12{cf_word[31]}}, cf_word[19:12], cf_word[20], cf_word[30:21], 1'b0};
   assign seq_pc   = base + 32'(BB);
   assign truncate = is_jal || is_jalr || (is_br && bp_resp_taken);

   always_comb begin
      mask  = '0;
      count = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         mask[i] = (i >= int'(start)) && (!truncate || i <= int'(cf_slot));
         count   = count + (SLOT_W+1)'(mask[i]);
      end
   end

   always_comb begin
      next_pc = seq_pc;
      if (is_jal)
         next_pc = slot_pc + jimm;
      else if (is_br && bp_resp_taken)
         next_pc = bp_resp_target;
   end

   assign block_next = is_jalr && JALR_STALL;
   assign room       = (32'(ib_free_slots) >= 32'(count));
   assign push       = in_hold && !redirect_valid && room;

   assign ic_req_valid      = reset_n && (state == S_IDLE) && !redirect_valid;
   assign ic_req_addr       = {pc[31:OFF_W], {OFF_W{1'b0}}};
   assign bp_req_valid      = in_hold && is_br;
   assign bp_req_pc         = bp_req_valid ? slot_pc : 32'h0;
   assign fetch_valid       = push ? mask : '0;
   assign fetch_inst        = bundle;
   assign fetch_is_branch   = (push && is_br) ? (FETCH_WIDTH'(1) << cf_slot) : '0;
   assign fetch_pred_taken  = push && is_br && bp_resp_taken;
   assign fetch_pred_target = (push && is_br) ? bp_resp_target : 32'h0;
   assign dbg_state         = state;
   assign unused_bits       = ^{pc[1:0], cf_word[11:7]};

   for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_pc
      assign fetch_pc[32*g +: 32] = reset_n ? (base + 32'(4*g)) : 32'h0;
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      kill_n  = kill;
      capture = 1'b0;
      latch   = 1'b0;
      case (state)
         S_IDLE: begin
            if (redirect_valid)
               pc_n = redirect_pc;
            else if (ic_req_valid && ic_req_ready) begin
               capture = 1'b1;
               state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_n = redirect_pc;
               if (ic_resp_valid) begin
                  kill_n  = 1'b0;
                  state_n = S_IDLE;
               end else
                  kill_n = 1'b1;
            end else if (ic_resp_valid) begin
               if (kill) begin
                  kill_n  = 1'b0;
                  state_n = S_IDLE;
               end else begin
                  latch   = 1'b1;
                  state_n = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_n    = redirect_pc;
               state_n = S_IDLE;
            end else if (push) begin
               pc_n    = next_pc;
               state_n = block_next ? S_BLOCK : S_IDLE;
            end
         end
         S_BLOCK: begin
            if (redirect_valid) begin
               pc_n    = redirect_pc;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         pc    <= RESET_PC;
         kill  <= 1'b0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         kill  <= kill_n;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         base   <= 32'h0;
         start  <= '0;
         bundle <= '0;
      end else begin
         if (capture) begin
            base  <= {pc[31:OFF_W], {OFF_W{1'b0}}};
            start <= pc[OFF_W-1:2];
         end
         if (latch)
            bundle <= ic_resp_data;
      end
   end

endmodule

// File: doc/stage_fetch_multi.md
Name: stage_fetch_multi

Overview:
Parametrised, decoupled fetch stage that replaces the single-cycle combinational fetch path. It issues one aligned bundle request at a time to the icache through a valid/ready request and response handshake, and latches the returned bundle. It predecodes control flow, queries the branch predictor and pushes a truncated bundle into the instruction buffer. It handles redirects that arrive while a request is in flight, and has an optional mode that stalls fetch on JALR until the backend redirects.

Parameters:
FETCH_WIDTH, 4, instructions per bundle; power of 2, range 2..8. Bundle byte size BB = FETCH_WIDTH*4.
IB_CNT_W, 4, width of ib_free_slots.
RESET_PC, 32'h0, PC value after reset.
JALR_STALL, 1, 1 = block fetch after JALR until redirect; 0 = fall through to the next bundle.

Ports:
clock  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
ic_req_valid  out  1  bundle request valid.
ic_req_ready  in  1  icache accepts request.
ic_req_addr  out  32  BB-aligned request address.
ic_resp_valid  in  1  bundle response valid; at most one per accepted request, latency ≥1 cycle.
ic_resp_data  in  32*FETCH_WIDTH  words; slot i at bits [32i+31:32i].
bp_req_valid  out  1  predictor query valid (combinational from the bundle register).
bp_req_pc  out  32  PC of the first conditional branch.
bp_resp_taken  in  1  predicted taken (same cycle as the query).
bp_resp_target  in  32  predicted target.
redirect_valid  in  1  backend redirect (mispredict or JALR resolution).
redirect_pc  in  32  redirect target.
ib_free_slots  in  IB_CNT_W  free instruction buffer entries.
fetch_valid  out  FETCH_WIDTH  per-slot push valid.
fetch_pc  out  32*FETCH_WIDTH  per-slot PC.
fetch_inst  out  32*FETCH_WIDTH  per-slot instruction.
fetch_is_branch  out  FETCH_WIDTH  slot carries the predicted branch.
fetch_pred_taken  out  1  prediction for the flagged branch.
fetch_pred_target  out  32  predicted target for the flagged branch.

Behaviour:
- State: PC (32 bits), FSM {IDLE, WAIT, HOLD, BLOCK}, kill bit, bundle register (base address, start slot, FETCH_WIDTH words).
- Reset (async, reset_n=0): PC=RESET_PC, FSM=IDLE, kill=0. All outputs are 0 during reset, except that ic_req_addr is don't-care.
- IDLE: ic_req_valid=1, ic_req_addr = PC with bits [log2(BB)-1:0] cleared.
  - On ic_req_valid && ic_req_ready: capture base = aligned PC and start = PC[log2(BB)-1:2], then go to WAIT.
  - ic_req_valid=0 in any cycle with redirect_valid=1.
- WAIT: on ic_resp_valid:
  - kill=1: discard the data, clear kill, go to IDLE.
  - kill=0: latch the words, go to HOLD.
- HOLD (all combinational from the bundle register):
  - Slot mask: slot i is valid iff i ≥ start.
  - Find the first valid slot whose opcode is BRANCH, JAL or JALR.
  - JAL at slot j: truncate slots > j; next = (base + 4j) + sign-extended J-immediate (32-bit wraparound).
  - JALR at slot j: truncate slots > j. JALR_STALL=1 → next state BLOCK. JALR_STALL=0 → next = base + BB.
  - BRANCH at slot j: bp_req_valid=1, bp_req_pc = base + 4j.
    - If bp_resp_taken: truncate slots > j, next = bp_resp_target.
    - Otherwise next = base + BB. Set fetch_is_branch[j].
  - No control flow: next = base + BB.
  - count = popcount of the final mask.
  - Push when ib_free_slots ≥ count: fetch_valid = mask for that cycle only, PC ← next, FSM ← IDLE (or BLOCK for a stalled JALR).
  - Otherwise hold: fetch_valid=0, bundle retained, predictor re-queried every cycle.
- BLOCK: ic_req_valid=0; leave only on redirect.
- Redirect (highest priority; overrides push and PC update in the same cycle): PC ← redirect_pc.
  - IDLE: stay IDLE.
  - WAIT without same-cycle response: kill ← 1, stay WAIT.
  - WAIT with same-cycle response: discard it, go to IDLE, kill=0.
  - HOLD: drop the bundle with no push, go to IDLE.
  - BLOCK: go to IDLE.
- Repeated redirects while kill=1: only PC updates.
- fetch_pc[i] = base + 4i for every slot. fetch_inst carries the raw words. fetch_pred_* are 0 when no branch is flagged.
- Reset asserted mid-WAIT: the late response arriving after reset release while in IDLE is ignored (ic_resp_valid is ignored outside WAIT).

Test Plan:
1. FETCH_WIDTH=4, reset release, req_ready=1, response after 3 cycles with 4 ADDI, ib_free_slots=8 → fetch_valid=4'b1111, fetch_pc 0x0/0x4/0x8/0xC, next ic_req_addr=0x10.
2. Redirect to 0x24 → ic_req_addr=0x20; response → fetch_valid=4'b1110 (start slot 1).
3. Response with BEQ at slot 1, bp_resp_taken=1, target 0x100 → fetch_valid=4'b0011, fetch_is_branch=4'b0010, next ic_req_addr=0x100.
4. Redirect 0x400 one cycle before ic_resp_valid in WAIT → response discarded, no push, next request address 0x400.
5. JALR at slot 2, JALR_STALL=1 → push 4'b0111, ic_req_valid=0 until redirect 0x80, then request 0x80.
6. count=4, ib_free_slots=3 for 5 cycles → no push, bundle held; free=4 → single push, PC advances once.
